// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//
// Tracks the destination registers that two issue slots have claimed and that
// have not yet been retired. A register goes busy when an instruction that
// writes it issues. It stops being busy when a writeback port retires it. Load
// destinations also carry a load-pending flag until the load data returns.
// All outputs are registered.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   iss{0,1}_valid/rd/reg_write/is_load
//                              issue slot descriptors (slot1 is younger)
//   wb{0,1}_valid/rd           writeback ports that retire register writes
//   ld_done_valid/rd           load data returned; the value can be forwarded
//   flush                      drop all in-flight tracking
//   busy_vec[31:0]             register has an outstanding producer
//   load_pending_vec[31:0]     outstanding producer is a load without data yet
//   inflight_cnt[5:0]          popcount of busy_vec
//   idle                       busy_vec == 0
//   err_wb_idle                sticky: a writeback named a register that was
//                              not busy
// -----------------------------------------------------------------------------
module reg_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss0_valid,
  input  logic [4:0]  iss0_rd,
  input  logic        iss0_reg_write,
  input  logic        iss0_is_load,
  input  logic        iss1_valid,
  input  logic [4:0]  iss1_rd,
  input  logic        iss1_reg_write,
  input  logic        iss1_is_load,
  input  logic        wb0_valid,
  input  logic [4:0]  wb0_rd,
  input  logic        wb1_valid,
  input  logic [4:0]  wb1_rd,
  input  logic        ld_done_valid,
  input  logic [4:0]  ld_done_rd,
  input  logic        flush,
  output logic [31:0] busy_vec,
  output logic [31:0] load_pending_vec,
  output logic [5:0]  inflight_cnt,
  output logic        idle,
  output logic        err_wb_idle
);

  logic [31:0] busy_reg, busy_next;
  logic [31:0] lp_reg, lp_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic        idle_reg;
  logic        err_reg, err_next;

  // x0 is hardwired to zero, so it can never hold an outstanding producer.
  assign busy_next[0] = 1'b0;
  assign lp_next[0]   = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic set0, set1, wb_clr, ld_clr;

      assign set0   = iss0_valid && iss0_reg_write && (iss0_rd == 5'(gi));
      assign set1   = iss1_valid && iss1_reg_write && (iss1_rd == 5'(gi));
      assign wb_clr = (wb0_valid && (wb0_rd == 5'(gi))) ||
                      (wb1_valid && (wb1_rd == 5'(gi)));
      assign ld_clr = ld_done_valid && (ld_done_rd == 5'(gi));

      // Clears are applied first and sets after them, so a new producer wins
      // over the retirement of an older one. When both slots set the same
      // register, slot1 is the younger one and its load flag is the one kept.
      assign busy_next[gi] = flush         ? 1'b0 :
                             (set0 || set1) ? 1'b1 :
                             wb_clr         ? 1'b0 : busy_reg[gi];

      assign lp_next[gi]   = flush              ? 1'b0         :
                             set1               ? iss1_is_load :
                             set0               ? iss0_is_load :
                             (wb_clr || ld_clr) ? 1'b0         : lp_reg[gi];
    end
  endgenerate

  // The count is taken from the next state so that it is registered in the
  // same edge as busy_vec and always agrees with it.
  always_comb begin
    cnt_next = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt_next = cnt_next + {5'd0, busy_next[i]};
    end
  end

  // A retirement is only legitimate for a register that was already busy in
  // the current state. An issue in the same cycle cannot be the producer
  // being retired.
  always_comb begin
    err_next = err_reg;
    if (wb0_valid && (wb0_rd != 5'd0) && !busy_reg[wb0_rd]) err_next = 1'b1;
    if (wb1_valid && (wb1_rd != 5'd0) && !busy_reg[wb1_rd]) err_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= 32'd0;
      lp_reg   <= 32'd0;
      cnt_reg  <= 6'd0;
      idle_reg <= 1'b1;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      lp_reg   <= lp_next;
      cnt_reg  <= cnt_next;
      idle_reg <= (busy_next == 32'd0);
      err_reg  <= err_next;
    end
  end

  assign busy_vec         = busy_reg;
  assign load_pending_vec = lp_reg;
  assign inflight_cnt     = cnt_reg;
  assign idle             = idle_reg;
  assign err_wb_idle      = err_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Drives a table of issue/writeback/flush vectors into reg_scoreboard. The
// expected register state for each vector goes into a queue when the vector is
// driven, and it is popped and compared once the clock edge has updated the
// DUT. Hand-written sequences then cover reset behaviour: reset held with
// activity on the inputs, the first update after release, and an asynchronous
// reset in the middle of a cycle with every register busy.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iss0_valid = 1'b0, iss0_reg_write = 1'b0, iss0_is_load = 1'b0;
  logic [4:0]  iss0_rd = 5'd0;
  logic        iss1_valid = 1'b0, iss1_reg_write = 1'b0, iss1_is_load = 1'b0;
  logic [4:0]  iss1_rd = 5'd0;
  logic        wb0_valid = 1'b0, wb1_valid = 1'b0, ld_done_valid = 1'b0;
  logic [4:0]  wb0_rd = 5'd0, wb1_rd = 5'd0, ld_done_rd = 5'd0;
  logic        flush = 1'b0;
  logic [31:0] busy_vec, load_pending_vec;
  logic [5:0]  inflight_cnt;
  logic        idle, err_wb_idle;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .iss0_valid(iss0_valid), .iss0_rd(iss0_rd),
    .iss0_reg_write(iss0_reg_write), .iss0_is_load(iss0_is_load),
    .iss1_valid(iss1_valid), .iss1_rd(iss1_rd),
    .iss1_reg_write(iss1_reg_write), .iss1_is_load(iss1_is_load),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
    .ld_done_valid(ld_done_valid), .ld_done_rd(ld_done_rd),
    .flush(flush),
    .busy_vec(busy_vec), .load_pending_vec(load_pending_vec),
    .inflight_cnt(inflight_cnt), .idle(idle), .err_wb_idle(err_wb_idle)
  );

  typedef struct {
    logic        i0v; logic [4:0] i0rd; logic i0w; logic i0l;
    logic        i1v; logic [4:0] i1rd; logic i1w; logic i1l;
    logic        w0v; logic [4:0] w0rd;
    logic        w1v; logic [4:0] w1rd;
    logic        ldv; logic [4:0] ldrd;
    logic        fl;
    logic [31:0] eb; logic [31:0] elp; logic [5:0] ecnt; logic eidle; logic eerr;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] eb; logic [31:0] elp; logic [5:0] ecnt; logic eidle; logic eerr;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] eb, input logic [31:0] elp,
                         input logic [5:0] ecnt, input logic eidle, input logic eerr);
    chk({tag, " busy_vec"}, busy_vec, eb);
    chk({tag, " load_pending_vec"}, load_pending_vec, elp);
    chk({tag, " inflight_cnt"}, {26'd0, inflight_cnt}, {26'd0, ecnt});
    chk({tag, " idle"}, {31'd0, idle}, {31'd0, eidle});
    chk({tag, " err_wb_idle"}, {31'd0, err_wb_idle}, {31'd0, eerr});
  endtask

  task automatic drive_idle();
    iss0_valid = 1'b0; iss0_rd = 5'd0; iss0_reg_write = 1'b0; iss0_is_load = 1'b0;
    iss1_valid = 1'b0; iss1_rd = 5'd0; iss1_reg_write = 1'b0; iss1_is_load = 1'b0;
    wb0_valid = 1'b0; wb0_rd = 5'd0; wb1_valid = 1'b0; wb1_rd = 5'd0;
    ld_done_valid = 1'b0; ld_done_rd = 5'd0; flush = 1'b0;
  endtask

  initial begin
    exp_t e;
    vec_t v;

    // i0v i0rd i0w i0l | i1v i1rd i1w i1l | w0v w0rd | w1v w1rd | ldv ldrd | fl | busy lp cnt idle err
    tbl.push_back('{1'b1,5'd5,1'b1,1'b1, 1'b1,5'd7,1'b1,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h000000A0,32'h00000020,6'd2,1'b0,1'b0});
    tbl.push_back('{1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd5, 1'b0, 32'h000000A0,32'h00000000,6'd2,1'b0,1'b0});
    tbl.push_back('{1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b1,5'd5, 1'b1,5'd7, 1'b0,5'd0, 1'b0, 32'h00000000,32'h00000000,6'd0,1'b1,1'b0});
    tbl.push_back('{1'b1,5'd9,1'b1,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h00000200,32'h00000000,6'd1,1'b0,1'b0});
    // retire and re-issue r9 together: the new load producer wins
    tbl.push_back('{1'b1,5'd9,1'b1,1'b1, 1'b0,5'd0,1'b0,1'b0, 1'b1,5'd9, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h00000200,32'h00000200,6'd1,1'b0,1'b0});
    // events naming x0 are ignored
    tbl.push_back('{1'b1,5'd0,1'b1,1'b1, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h00000200,32'h00000200,6'd1,1'b0,1'b0});
    tbl.push_back('{1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b1,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h00000200,32'h00000200,6'd1,1'b0,1'b0});
    // both slots name r12 (slot1 ALU wins), then r13 (slot1 load wins)
    tbl.push_back('{1'b1,5'd12,1'b1,1'b1, 1'b1,5'd12,1'b1,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h00001200,32'h00000200,6'd2,1'b0,1'b0});
    tbl.push_back('{1'b1,5'd13,1'b1,1'b0, 1'b1,5'd13,1'b1,1'b1, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h00003200,32'h00002200,6'd3,1'b0,1'b0});
    // no reg_write / no valid: nothing changes
    tbl.push_back('{1'b1,5'd14,1'b0,1'b1, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h00003200,32'h00002200,6'd3,1'b0,1'b0});
    tbl.push_back('{1'b0,5'd15,1'b1,1'b1, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h00003200,32'h00002200,6'd3,1'b0,1'b0});
    // both wb ports name r12: cleared once, no error
    tbl.push_back('{1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b1,5'd12, 1'b1,5'd12, 1'b0,5'd0, 1'b0, 32'h00002200,32'h00002200,6'd2,1'b0,1'b0});
    tbl.push_back('{1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b1,5'd13, 1'b0,5'd0, 1'b1,5'd9, 1'b0, 32'h00000200,32'h00000000,6'd1,1'b0,1'b0});
    tbl.push_back('{1'b1,5'd9,1'b1,1'b1, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd9, 1'b0, 32'h00000200,32'h00000200,6'd1,1'b0,1'b0});
    tbl.push_back('{1'b1,5'd12,1'b1,1'b0, 1'b1,5'd13,1'b1,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h00003200,32'h00000200,6'd3,1'b0,1'b0});
    tbl.push_back('{1'b1,5'd14,1'b1,1'b0, 1'b1,5'd15,1'b1,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h0000F200,32'h00000200,6'd5,1'b0,1'b0});
    tbl.push_back('{1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b1,5'd9, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h0000F000,32'h00000000,6'd4,1'b0,1'b0});
    // flush overrides a same-cycle set and clear
    tbl.push_back('{1'b1,5'd3,1'b1,1'b1, 1'b0,5'd0,1'b0,1'b0, 1'b1,5'd12, 1'b0,5'd0, 1'b0,5'd0, 1'b1, 32'h00000000,32'h00000000,6'd0,1'b1,1'b0});
    // writeback to an idle register raises the sticky error
    tbl.push_back('{1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b1,5'd4, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h00000000,32'h00000000,6'd0,1'b1,1'b1});
    tbl.push_back('{1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 32'h00000000,32'h00000000,6'd0,1'b1,1'b1});
    tbl.push_back('{1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0,1'b0,1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b1, 32'h00000000,32'h00000000,6'd0,1'b1,1'b1});

    // Asynchronous reset from time zero
    #2 rst = 1'b1;
    #1 chk_all("reset", 32'd0, 32'd0, 6'd0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      iss0_valid = v.i0v; iss0_rd = v.i0rd; iss0_reg_write = v.i0w; iss0_is_load = v.i0l;
      iss1_valid = v.i1v; iss1_rd = v.i1rd; iss1_reg_write = v.i1w; iss1_is_load = v.i1l;
      wb0_valid = v.w0v; wb0_rd = v.w0rd; wb1_valid = v.w1v; wb1_rd = v.w1rd;
      ld_done_valid = v.ldv; ld_done_rd = v.ldrd; flush = v.fl;
      sb.push_back('{i, v.eb, v.elp, v.ecnt, v.eidle, v.eerr});
      @(posedge clk); #1;
      e = sb.pop_front();
      chk_all($sformatf("vec%0d", e.idx), e.eb, e.elp, e.ecnt, e.eidle, e.eerr);
      $display("[TB] vec %0d busy=0x%08h lp=0x%08h cnt=%0d idle=%0d err=%0d",
               e.idx, busy_vec, load_pending_vec, inflight_cnt, idle, err_wb_idle);
    end
    drive_idle();

    // Reset held while the inputs are active: nothing is recorded
    rst = 1'b1;
    #1 chk_all("rst_clears_err", 32'd0, 32'd0, 6'd0, 1'b1, 1'b0);
    iss0_valid = 1'b1; iss0_rd = 5'd5; iss0_reg_write = 1'b1; iss0_is_load = 1'b1;
    wb1_valid = 1'b1; wb1_rd = 5'd6;
    @(posedge clk); #1;
    chk_all("rst_held", 32'd0, 32'd0, 6'd0, 1'b1, 1'b0);
    @(negedge clk) rst = 1'b0;
    wb1_valid = 1'b0;
    @(posedge clk); #1;
    chk_all("first_after_rst", 32'h00000020, 32'h00000020, 6'd1, 1'b0, 1'b0);
    $display("[TB] first edge after reset busy=0x%08h", busy_vec);
    drive_idle();

    // Make r1..r31 busy one per cycle, then reset asynchronously in mid-cycle
    for (int r = 1; r < 32; r++) begin
      iss1_valid = 1'b1; iss1_rd = 5'(r); iss1_reg_write = 1'b1; iss1_is_load = r[0];
      @(posedge clk); #1;
    end
    drive_idle();
    chk_all("all_busy", 32'hFFFFFFFE, 32'hAAAAAAAA, 6'd31, 1'b0, 1'b0);
    $display("[TB] all busy cnt=%0d busy=0x%08h", inflight_cnt, busy_vec);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 32'd0, 32'd0, 6'd0, 1'b1, 1'b0);
    $display("[TB] async reset busy=0x%08h idle=%0d", busy_vec, idle);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk_all("after_async_rst", 32'd0, 32'd0, 6'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
